// File: rtl/mem_bus_arbiter.sv
// Shares one cyc/stb/ack memory bus between instruction fetch and the data-memory stage.
// MEM has fixed priority over IF; results are held while the owner is stalled.
module mem_bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall_i,
    input  logic              flush_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_stallreq_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_stallreq_o,
    output logic              bus_cyc_o,
    output logic              bus_stb_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_sel_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i,
    output logic              bus_err_o
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_WAIT_STALL, S_DRAIN} state_t;
    typedef enum logic {OWN_IF, OWN_MEM} owner_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t            state;
    owner_t            owner;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [DATA_W-1:0] hold_q;

    logic              owner_stall;
    logic              on_bus;
    logic              timeout;
    logic              bus_end;
    logic              owner_done;
    logic [DATA_W-1:0] owner_data;
    logic              if_done;
    logic              mem_done;
    logic              unused_stall;

    assign unused_stall = ^{stall_i[5], stall_i[3:2], stall_i[0]};

    assign owner_stall = (owner == OWN_MEM) ? stall_i[4] : stall_i[1];
    assign on_bus      = (state == S_BUSY) || (state == S_DRAIN);
    assign timeout     = on_bus && !bus_ack_i && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_end     = on_bus && (bus_ack_i || timeout);
    assign bus_err_o   = timeout;

    // owner_done: the owner is released this cycle, either with data or by timeout abort.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        owner_done = 1'b0;
        owner_data = '0;
        case (state)
            S_BUSY: begin
                if (bus_ack_i && !flush_i) begin
                    owner_done = 1'b1;
                    owner_data = bus_rdata_i;
                end else if (timeout) begin
                    owner_done = 1'b1;
                end
            end
            S_WAIT_STALL: begin
                if (!flush_i) begin
                    owner_done = 1'b1;
                    owner_data = hold_q;
                end
            end
            default: ;
        endcase
    end

    assign if_done        = owner_done && (owner == OWN_IF);
    assign mem_done       = owner_done && (owner == OWN_MEM);
    assign if_rdata_o     = if_done ? owner_data : '0;
    assign mem_rdata_o    = mem_done ? owner_data : '0;
    assign if_stallreq_o  = if_req_i && !if_done;
    assign mem_stallreq_o = mem_req_i && !mem_done;

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // read in this block sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            owner       <= OWN_IF;
            tmo_cnt     <= '0;
            hold_q      <= '0;
            bus_cyc_o   <= 1'b0;
            bus_stb_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_sel_o   <= 4'h0;
            bus_wdata_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tmo_cnt <= '0;
                    if (!flush_i && mem_req_i) begin
                        owner       <= OWN_MEM;
                        state       <= S_BUSY;
                        bus_cyc_o   <= 1'b1;
                        bus_stb_o   <= 1'b1;
                        bus_we_o    <= mem_we_i;
                        bus_addr_o  <= mem_addr_i;
                        bus_sel_o   <= mem_sel_i;
                        bus_wdata_o <= mem_wdata_i;
                    end else if (!flush_i && if_req_i) begin
                        owner       <= OWN_IF;
                        state       <= S_BUSY;
                        bus_cyc_o   <= 1'b1;
                        bus_stb_o   <= 1'b1;
                        bus_we_o    <= 1'b0;
                        bus_addr_o  <= if_addr_i;
                        bus_sel_o   <= 4'hF;
                        bus_wdata_o <= '0;
                    end
                end
                S_BUSY: begin
                    if (bus_ack_i) begin
                        hold_q <= bus_rdata_i;
                        state  <= (!flush_i && owner_stall) ? S_WAIT_STALL : S_IDLE;
                    end else if (timeout) begin
                        state <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (flush_i) state <= S_DRAIN;
                    end
                end
                // A flushed cycle keeps the bus signals stable until the slave finishes.
                S_DRAIN: begin
                    if (bus_ack_i || timeout) state <= S_IDLE;
                    else tmo_cnt <= tmo_cnt + 1'b1;
                end
                S_WAIT_STALL: begin
                    if (flush_i || !owner_stall) begin
                        state  <= S_IDLE;
                        hold_q <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (bus_end) begin
                bus_cyc_o   <= 1'b0;
                bus_stb_o   <= 1'b0;
                bus_we_o    <= 1'b0;
                bus_addr_o  <= '0;
                bus_sel_o   <= 4'h0;
                bus_wdata_o <= '0;
                tmo_cnt     <= '0;
            end
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one external memory bus (single-master, cyc/stb/ack style) between instruction fetch (IF) and the data-memory stage (MEM).
- Sits between pc_reg/if_id and mem on one side and the memory slave on the other.
- Raises stall requests to ctrl while a requester waits for the bus or for data.
- Holds completed results while the pipeline is stalled, and drains bus cycles on flush.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 255, maximum BUSY cycles without ack before abort (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- stall_i  in  6  pipeline stall vector from ctrl; bit1 = IF owner stalled, bit4 = MEM owner stalled
- flush_i  in  1  pipeline flush; discard in-flight/held results
- if_req_i  in  1  instruction fetch request (level)
- if_addr_i  in  ADDR_W  fetch address
- if_rdata_o  out  DATA_W  fetched instruction
- if_stallreq_o  out  1  IF stall request to ctrl
- mem_req_i  in  1  data access request (level)
- mem_we_i  in  1  1 = store
- mem_addr_i  in  ADDR_W  data address
- mem_sel_i  in  4  byte enables
- mem_wdata_i  in  DATA_W  store data
- mem_rdata_o  out  DATA_W  load data
- mem_stallreq_o  out  1  MEM stall request to ctrl
- bus_cyc_o  out  1  bus cycle
- bus_stb_o  out  1  strobe
- bus_we_o  out  1  write enable
- bus_addr_o  out  ADDR_W  address
- bus_sel_o  out  4  byte select
- bus_wdata_o  out  DATA_W  write data
- bus_rdata_i  in  DATA_W  read data
- bus_ack_i  in  1  slave acknowledge
- bus_err_o  out  1  one-cycle timeout pulse

Behaviour:
- Reset (sync, active-high): state IDLE; all outputs 0; hold register, owner and timeout counter cleared. Reset mid-transaction: cyc/stb low on the following cycle, no result delivered.
- States:
  - IDLE
  - BUSY: bus owned by owner (IF or MEM).
  - WAIT_STALL: result held for owner.
  - DRAIN: flushed cycle completing.
- IDLE arbitration, fixed priority MEM > IF:
  - If flush_i=0 and mem_req_i=1: register the bus outputs from mem_*, owner=MEM, go to BUSY.
  - Else if flush_i=0 and if_req_i=1: bus_we_o=0, bus_sel_o=4'hF, owner=IF, go to BUSY.
  - Bus outputs are registered: cyc/stb rise the cycle after the request is seen.
- Stall requests (combinational):
  - X_stallreq_o=1 whenever X_req_i=1 and that requester's result is not deliverable this cycle. This covers IDLE-issue, BUSY without ack, losing arbitration, and DRAIN.
  - In the ack cycle for the owner, the owner's stallreq_o=0 and X_rdata_o=bus_rdata_i (combinational bypass).
- BUSY with bus_ack_i=1:
  - Capture bus_rdata_i into the hold register; cyc/stb/we/sel drop to 0 next edge; counter clears.
  - If the owner's stall bit is 1, go to WAIT_STALL; else go to IDLE.
- WAIT_STALL:
  - Owner's rdata_o = hold register; owner's stallreq_o=0; no new bus cycle.
  - Return to IDLE on the first cycle the owner's stall bit is 0.
- Non-owner in BUSY or WAIT_STALL: rdata_o=0, stallreq_o=req.
- Timeout:
  - The counter increments each BUSY/DRAIN cycle without ack.
  - At count == TIMEOUT_CYCLES-1 with no ack: drop cyc/stb next edge, bus_err_o=1 for one cycle, owner's rdata_o=0, owner's stallreq_o=0 that cycle, go to IDLE.
- Flush:
  - flush_i in BUSY: go to DRAIN. Bus signals are held until ack or timeout, then IDLE; no rdata delivered; a store still completes.
  - flush_i in WAIT_STALL: go to IDLE, hold register discarded.
  - flush_i in IDLE: no issue this cycle.
- Ack in the same cycle as flush: transaction is complete, no data delivered, go to IDLE.
- Ack outside BUSY/DRAIN: ignored.
- The owner's request deasserting while in BUSY does not abort the bus cycle.
- bus_wdata_o = 0 for IF reads.

Test Plan:
- IF read only: if_req=1, addr 0x100; slave acks 2 cycles after stb with 0x3C010001 -> cyc/stb high 2 cycles; if_stallreq 1 until the ack cycle; if_rdata=0x3C010001 on ack; state back to IDLE.
- Simultaneous requests: if_req and mem_req (load 0x200) in the same cycle -> MEM granted first, if_stallreq held 1 throughout; IF issued on the cycle after MEM completes.
- Store: mem_we=1, sel=4'b0011, wdata=0xDEADBEEF -> bus_we=1, sel=0011, wdata matches; mem_stallreq drops on ack.
- Stall hold: ack with 0x12345678 while stall_i[1]=1 for 3 cycles -> WAIT_STALL; if_rdata=0x12345678 all 3 cycles; no new cyc until stall_i[1]=0.
- Flush mid-read: flush_i pulse during an IF BUSY -> cyc held until ack; if_rdata=0; no stall-hold; next if_req issues a fresh cycle.
- Timeout with TIMEOUT_CYCLES=4 and no ack -> cyc drops after 4 BUSY cycles; bus_err_o single pulse; stallreq released; rdata=0.
